// File: rtl/skid_fifo_if.sv
// Valid/ready stream pair for skid_fifo: ingress (i_*) and egress (e_*) channels.
interface skid_fifo_if #(
    parameter int DATA_W = 8
);
    logic              i_valid_i;
    logic [DATA_W-1:0] i_data_i;
    logic              i_ready_o;
    logic              e_ready_i;
    logic              e_valid_o;
    logic [DATA_W-1:0] e_data_o;

    // Environment side: drives ingress data and egress ready.
    modport master (
        output i_valid_i, i_data_i, e_ready_i,
        input  i_ready_o, e_valid_o, e_data_o
    );

    // Buffer side.
    modport slave (
        input  i_valid_i, i_data_i, e_ready_i,
        output i_ready_o, e_valid_o, e_data_o
    );
endinterface

// File: rtl/skid_fifo.sv
// DEPTH-entry elastic buffer with registered ingress ready, occupancy and flush.
module skid_fifo #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 2,
    localparam int LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    skid_fifo_if.slave       bus,
    output logic [LVL_W-1:0] level_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] storage [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  count_q;
    logic [LVL_W-1:0]  count_next;
    logic              ready_q;
    logic              push;
    logic              pop;

    // Handshakes and next occupancy; ready depends only on ready_q, never on e_ready_i.
    always_comb begin
        push       = bus.i_valid_i & ready_q;
        pop        = (count_q != '0) & bus.e_ready_i;
        count_next = count_q + LVL_W'(push) - LVL_W'(pop);
    end

    // Pointer, occupancy, ready and storage update; reset beats flush beats transfers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) storage[i] <= '0;
        end else if (flush_i) begin
            // Contents are left in place; pointers and count make them unreachable.
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ready_q <= 1'b1;
        end else begin
            if (push) begin
                storage[wr_ptr] <= bus.i_data_i;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_next;
            // Looking at count_next lets a pop while full reopen ingress at the next edge.
            ready_q <= (count_next != LVL_W'(DEPTH));
        end
    end

    assign bus.i_ready_o = ready_q;
    assign bus.e_valid_o = (count_q != '0);
    assign bus.e_data_o  = storage[rd_ptr];
    assign level_o       = count_q;
endmodule

// File: tb/tb_skid_fifo.sv
// Directed bench for skid_fifo: DEPTH=2 and DEPTH=4 instances side by side.
module tb_skid_fifo;
    logic       clk = 1'b0;
    logic       rst2_n, rst4_n, flush2, flush4;
    logic [1:0] level2;
    logic [2:0] level4;
    int         total  = 0;
    int         passed = 0;

    skid_fifo_if #(.DATA_W(8)) m2 ();
    skid_fifo_if #(.DATA_W(8)) m4 ();

    skid_fifo #(.DATA_W(8), .DEPTH(2)) u2 (
        .clk(clk), .rst_n(rst2_n), .flush_i(flush2), .bus(m2), .level_o(level2)
    );
    skid_fifo #(.DATA_W(8), .DEPTH(4)) u4 (
        .clk(clk), .rst_n(rst4_n), .flush_i(flush4), .bus(m4), .level_o(level4)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        logic [7:0] q[$];
        int         mcount, popped, idx, cyc;
        logic       mready, pend, vld, rdy, push, pop;

        rst2_n = 1'b0; rst4_n = 1'b0; flush2 = 1'b0; flush4 = 1'b0;
        m2.i_valid_i = 1'b0; m2.i_data_i = '0; m2.e_ready_i = 1'b0;
        m4.i_valid_i = 1'b0; m4.i_data_i = '0; m4.e_ready_i = 1'b0;

        // Reset release
        tick;
        check("rst_ready", m2.i_ready_o, 0);
        check("rst_valid", m2.e_valid_o, 0);
        check("rst_level", level2, 0);
        check("rst_data", m2.e_data_o, 0);
        tick;
        rst2_n = 1'b1; rst4_n = 1'b1;
        check("rel_ready_pre", m2.i_ready_o, 0);
        tick;
        check("rel_ready", m2.i_ready_o, 1);
        check("rel_valid", m2.e_valid_o, 0);
        check("rel_level", level2, 0);
        check("rel_ready4", m4.i_ready_o, 1);

        // Backpressure fill, DEPTH=4
        for (int k = 0; k < 4; k++) begin
            m4.i_valid_i = 1'b1;
            m4.i_data_i  = 8'hA1 + 8'(k);
            tick;
            check("fill_level", level4, k + 1);
        end
        check("full_ready", m4.i_ready_o, 0);
        check("full_valid", m4.e_valid_o, 1);
        check("full_head", m4.e_data_o, 8'hA1);
        m4.i_data_i = 8'hA5;
        tick;
        check("full_hold_level", level4, 4);
        check("full_hold_ready", m4.i_ready_o, 0);
        check("full_hold_head", m4.e_data_o, 8'hA1);

        // Skid release
        m4.e_ready_i = 1'b1;
        tick;
        check("skid_data1", m4.e_data_o, 8'hA2);
        check("skid_ready", m4.i_ready_o, 1);
        check("skid_level1", level4, 3);
        tick;
        m4.i_valid_i = 1'b0;
        check("skid_data2", m4.e_data_o, 8'hA3);
        check("skid_level2", level4, 3);
        tick;
        check("skid_data3", m4.e_data_o, 8'hA4);
        check("skid_level3", level4, 2);
        tick;
        check("skid_data4", m4.e_data_o, 8'hA5);
        check("skid_level4", level4, 1);
        tick;
        check("skid_empty", m4.e_valid_o, 0);
        check("skid_level0", level4, 0);
        m4.e_ready_i = 1'b0;

        // Streaming, DEPTH=2
        m2.i_valid_i = 1'b1;
        m2.e_ready_i = 1'b1;
        for (int i = 0; i < 64; i++) begin
            m2.i_data_i = 8'(i);
            tick;
            check("stream_data", m2.e_data_o, i);
            check("stream_level", level2, 1);
        end
        m2.i_valid_i = 1'b0;
        tick;
        check("stream_drain", m2.e_valid_o, 0);
        m2.e_ready_i = 1'b0;

        // Wrap-around with random valid/ready, DEPTH=4, against a queue model
        mcount = 0; mready = 1'b1; popped = 0; idx = 0; pend = 1'b0; cyc = 0;
        while (popped < 200 && cyc < 5000) begin
            vld = pend ? 1'b1 : ((idx < 200) && ($urandom_range(0, 3) != 0));
            rdy = ($urandom_range(0, 2) != 0);
            m4.i_valid_i = vld;
            m4.i_data_i  = 8'(idx);
            m4.e_ready_i = rdy;
            push = vld & mready;
            pop  = (mcount != 0) & rdy;
            pend = vld & ~push;
            check("wrap_ready", m4.i_ready_o, mready);
            check("wrap_valid", m4.e_valid_o, (mcount != 0));
            check("wrap_level", level4, mcount);
            check("wrap_level_max", (level4 <= 3'd4), 1);
            if (mcount != 0) check("wrap_data", m4.e_data_o, q[0]);
            tick;
            if (pop) begin
                void'(q.pop_front());
                popped++;
            end
            if (push) begin
                q.push_back(8'(idx));
                idx++;
            end
            mcount = q.size();
            mready = (mcount != 4);
            cyc++;
        end
        check("wrap_done", popped, 200);
        m4.i_valid_i = 1'b0;
        m4.e_ready_i = 1'b0;
        tick;
        check("wrap_empty", level4, 0);

        // Flush, DEPTH=4
        m4.i_valid_i = 1'b1;
        m4.i_data_i  = 8'h11; tick;
        m4.i_data_i  = 8'h22; tick;
        m4.i_data_i  = 8'h33; tick;
        check("flush_pre_level", level4, 3);
        check("flush_pre_head", m4.e_data_o, 8'h11);
        flush4       = 1'b1;
        m4.i_data_i  = 8'h44;
        m4.e_ready_i = 1'b1;
        tick;
        flush4       = 1'b0;
        m4.i_valid_i = 1'b0;
        m4.e_ready_i = 1'b0;
        check("flush_level", level4, 0);
        check("flush_valid", m4.e_valid_o, 0);
        check("flush_ready", m4.i_ready_o, 1);
        m4.i_valid_i = 1'b1;
        m4.i_data_i  = 8'h55;
        tick;
        m4.i_valid_i = 1'b0;
        check("flush_next_data", m4.e_data_o, 8'h55);
        check("flush_next_level", level4, 1);

        // Reset mid-operation wipes contents at once
        rst4_n = 1'b0;
        tick;
        rst4_n = 1'b1;
        check("midrst_level", level4, 0);
        check("midrst_valid", m4.e_valid_o, 0);
        check("midrst_ready", m4.i_ready_o, 0);
        tick;
        check("midrst_ready_rel", m4.i_ready_o, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
